cmd_scheduler: RTL
==================

# cmd_scheduler

Shares the SD host command controller (`cmdcontrol`) between two requesters: the software register interface (port 0) and the data-transfer engine (port 1). It arbitrates round-robin and drives one command at a time into `cmdcontrol`. It also runs the response timeout counter that feeds `cmdcontrol`'s timeout inputs. When each command completes, it returns the response and status to the requester that issued it.

## Interface
- `TIMEOUT_W`, 16, width of the timeout counter and of `iTimeout_value`.
- `iClock_host` in 1: host clock; all logic on its rising edge.
- `iReset` in 1: asynchronous, active-low reset.
- `iReq0` / `iReq1` in 1 each: level command requests.
- `iIndex0` / `iIndex1` in 6 each: command index for each requester.
- `iArg0` / `iArg1` in 32 each: command argument for each requester.
- `oGnt0` / `oGnt1` out 1 each: high from grant until the done cycle inclusive.
- `oDone0` / `oDone1` out 1 each: one-cycle completion pulse.
- `oErr` out 2: status, valid with `oDone*`. 00 = ok, 01 = index error, 10 = timeout.
- `oRsp` out 38: response, valid with `oDone*` and held until the next done.
- `iTimeout_value` in `TIMEOUT_W`: timeout limit in cycles; 0 disables the timeout.
- `oNew_command` out 1: one-cycle pulse to `cmdcontrol.iNew_command`.
- `oCmd_index` out 6, `oCmd_argument` out 32: latched command, to `cmdcontrol`.
- `oTimeout_enable` out 1, `oTimeout` out 1: to `cmdcontrol.iTimeout_enable` / `iTimeout`.
- `iIdle` in 1: from `cmdcontrol.oIdle_out`.
- `iCommand_complete` in 1: from `cmdcontrol.oCommand_complete`.
- `iCommand_index_error` in 1: from `cmdcontrol.oCommand_index_error`.
- `iResponse` in 38: from `cmdcontrol.oResponse`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE when `iIdle`=1 and any `iReq*`=1. No transition while `iIdle`=0.
- Arbitration is round-robin on a last-granted pointer; after reset the pointer favours port 0.
  - If both requesters are asserting, the one not granted last wins.
  - If only one is asserting, it wins.
- On the IDLE → ISSUE edge, the winner's index and argument are latched into `oCmd_index` / `oCmd_argument`, its `oGnt` is set, and the pointer is updated. Latched values stay stable until the next grant.
- ISSUE: `oNew_command`=1 for exactly one cycle, the counter clears, then → WAIT.
- WAIT: the counter increments every cycle, saturating at its maximum value.
  - `oTimeout_enable` = (`iTimeout_value` ≠ 0) during ISSUE and WAIT, else 0.
  - `oTimeout` = 1 when enabled and counter == `iTimeout_value`; it stays high until DONE exits.
  - `iCommand_complete`=1 → latch `iResponse` into `oRsp`. `oErr` = 01 if `iCommand_index_error`, else 00. Then → DONE.
  - Otherwise, `oTimeout`=1 → `oErr`=10, `oRsp` unchanged, → DONE.
  - If complete and timeout occur in the same cycle, complete wins.
- DONE: `oDone` of the granted port is high for one cycle; `oGnt` drops at the end of DONE, then → IDLE.
- Requester rules:
  - `iReq` is ignored while that port is granted.
  - A request that is still high in the first IDLE cycle re-arbitrates, so back-to-back commands are legal; round-robin keeps them fair.
  - Deasserting `iReq` before grant cancels it with no side effects.
- With `iTimeout_value`=0, WAIT lasts until `iCommand_complete`.

## Timing
- Reset values:
  - All outputs 0: `oRsp`, `oCmd_index`, `oCmd_argument`, `oErr`, all strobes, grants and done pulses.
  - State = IDLE, counter = 0, pointer favours port 0.
- Reset asserted mid-command aborts it: no `oDone` is produced and the requester must re-request.
- Latency:
  - Request seen in IDLE at cycle N → `oGnt` and `oNew_command` high at N+1.
  - Counter = 1 at N+2.
  - `iCommand_complete` at cycle M → `oDone`, `oRsp` and `oErr` valid at M+1.
- Timeout: `oNew_command` at N+1 with limit T → `oTimeout` high at N+1+T, `oDone` at N+2+T.
- Minimum IDLE-to-IDLE command turnaround: 4 cycles (IDLE, ISSUE, WAIT, DONE).

## Structure
- Shared package `sd_cmd_pkg`:
  - FSM state encoding.
  - Error codes `ERR_OK` / `ERR_INDEX` / `ERR_TIMEOUT`.
  - Widths `CMD_INDEX_W`=6, `CMD_ARG_W`=32, `CMD_RSP_W`=38.
- One sub-module, `cmd_timeout_counter`, containing:
  - Counter with clear and increment.
  - Saturation at all-ones.
  - Compare against `iTimeout_value`, producing enable and timeout.
- Arbiter and FSM live in `cmd_scheduler`.

## Test plan
- Port 0 requests index 17, argument 0x0000_1234; `cmdcontrol` completes 10 cycles after `oNew_command` with response 0x2A_DEAD_BEEF. Expect:
  - `oNew_command` one cycle after the request.
  - `oCmd_index`=17 held throughout.
  - `oDone0` with `oRsp`=0x2A_DEAD_BEEF, `oErr`=00.
- Both ports request continuously for 4 commands. Expect the grant order 0, 1, 0, 1, with a `oNew_command` pulse per grant and no overlapping grants.
- `iTimeout_value`=5 and no complete. Expect:
  - `oTimeout` high 5 cycles after `oNew_command`.
  - `oDone1` the next cycle with `oErr`=10 and `oRsp` unchanged.
- `iCommand_complete` and the timeout land in the same cycle with `iCommand_index_error`=1. Expect `oErr`=01 and the response latched.
- `iIdle`=0 while `iReq0`=1. Expect no grant until `iIdle` rises, then a grant on the next cycle.
- `iReset` pulled low in WAIT. Expect all outputs 0 and no `oDone`. After reset, a new request from port 1 proceeds normally.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Types and widths shared by the SD host command scheduler and its helpers.
package sd_cmd_pkg;

    localparam int CMD_INDEX_W = 6;
    localparam int CMD_ARG_W   = 32;
    localparam int CMD_RSP_W   = 38;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } sched_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_INDEX   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } cmd_err_e;

    // Round-robin choice between two requesters; returns the winning port number.
    function automatic logic pickPort(input logic preferPort, input logic req0, input logic req1);
        if (req0 && req1) return preferPort;
        return req1;
    endfunction

endpackage

// File: rtl/cmd_scheduler_if.sv
// Bus between the scheduler (master) and the cmdcontrol command engine (slave).
interface cmd_scheduler_if;
    import sd_cmd_pkg::*;

    logic                   oNew_command;
    logic [CMD_INDEX_W-1:0] oCmd_index;
    logic [CMD_ARG_W-1:0]   oCmd_argument;
    logic                   oTimeout_enable;
    logic                   oTimeout;
    logic                   iIdle;
    logic                   iCommand_complete;
    logic                   iCommand_index_error;
    logic [CMD_RSP_W-1:0]   iResponse;

    modport master (
        output oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout,
        input  iIdle, iCommand_complete, iCommand_index_error, iResponse
    );

    modport slave (
        input  oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout,
        output iIdle, iCommand_complete, iCommand_index_error, iResponse
    );

endinterface

// File: rtl/cmd_timeout_counter.sv
// Response timeout counter: clears while idle, counts while a command is in flight,
// and freezes once it reaches the programmed limit so the timeout stays asserted.
module cmd_timeout_counter #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 iClock_host,
    input  logic                 iReset,
    input  logic                 iClear,
    input  logic                 iIncrement,
    input  logic                 iWindow,
    input  logic                 iHold,
    input  logic [TIMEOUT_W-1:0] iTimeout_value,
    output logic                 oTimeout_enable,
    output logic                 oTimeout
);

    logic [TIMEOUT_W-1:0] count;
    logic                 limitSet;
    logic                 atLimit;

    assign limitSet = (iTimeout_value != '0);
    assign atLimit  = limitSet && (count == iTimeout_value);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClock_host or negedge iReset) begin
        if (!iReset) begin
            count <= '0;
        end else if (iClear) begin
            count <= '0;
        end else if (iIncrement && !atLimit && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign oTimeout_enable = iWindow && limitSet;
    assign oTimeout        = (iWindow || iHold) && atLimit;

endmodule

// File: rtl/cmd_scheduler.sv
// Round-robin scheduler sharing one cmdcontrol between the register port (0)
// and the data-transfer engine (1), with response timeout and result return.
module cmd_scheduler
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic                   iClock_host,
    input  logic                   iReset,
    input  logic                   iReq0,
    input  logic                   iReq1,
    input  logic [CMD_INDEX_W-1:0] iIndex0,
    input  logic [CMD_INDEX_W-1:0] iIndex1,
    input  logic [CMD_ARG_W-1:0]   iArg0,
    input  logic [CMD_ARG_W-1:0]   iArg1,
    output logic                   oGnt0,
    output logic                   oGnt1,
    output logic                   oDone0,
    output logic                   oDone1,
    output logic [1:0]             oErr,
    output logic [CMD_RSP_W-1:0]   oRsp,
    input  logic [TIMEOUT_W-1:0]   iTimeout_value,
    cmd_scheduler_if.master        cmdBus
);

    sched_state_e           state;
    sched_state_e           nextState;
    logic                   preferPort;
    logic                   winner;
    logic                   grantNow;
    logic                   timeoutHit;
    logic                   gnt0;
    logic                   gnt1;
    logic [CMD_INDEX_W-1:0] cmdIndex;
    logic [CMD_ARG_W-1:0]   cmdArgument;
    logic [CMD_RSP_W-1:0]   rspReg;
    cmd_err_e               errCode;

    always_ff @(posedge iClock_host or negedge iReset) begin
        if (!iReset) state <= ST_IDLE;
        else         state <= nextState;
    end

    // NOTE: nextState is given its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (cmdBus.iIdle && (iReq0 || iReq1)) nextState = ST_ISSUE;
            ST_ISSUE: nextState = ST_WAIT;
            ST_WAIT:  if (cmdBus.iCommand_complete || timeoutHit) nextState = ST_DONE;
            ST_DONE:  nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    assign winner   = pickPort(preferPort, iReq0, iReq1);
    assign grantNow = (state == ST_IDLE) && (nextState == ST_ISSUE);

    always_ff @(posedge iClock_host or negedge iReset) begin
        if (!iReset) begin
            preferPort  <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            cmdIndex    <= '0;
            cmdArgument <= '0;
            rspReg      <= '0;
            errCode     <= ERR_OK;
        end else begin
            if (grantNow) begin
                preferPort  <= ~winner;
                gnt0        <= ~winner;
                gnt1        <= winner;
                cmdIndex    <= winner ? iIndex1 : iIndex0;
                cmdArgument <= winner ? iArg1 : iArg0;
            end else if (state == ST_DONE) begin
                gnt0 <= 1'b0;
                gnt1 <= 1'b0;
            end
            // A completion in the same cycle as the timeout takes priority.
            if ((state == ST_WAIT) && cmdBus.iCommand_complete) begin
                rspReg  <= cmdBus.iResponse;
                errCode <= cmdBus.iCommand_index_error ? ERR_INDEX : ERR_OK;
            end else if ((state == ST_WAIT) && timeoutHit) begin
                errCode <= ERR_TIMEOUT;
            end
        end
    end

    cmd_timeout_counter #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
        .iClock_host     (iClock_host),
        .iReset          (iReset),
        .iClear          (state == ST_IDLE),
        .iIncrement      ((state == ST_ISSUE) || (state == ST_WAIT)),
        .iWindow         ((state == ST_ISSUE) || (state == ST_WAIT)),
        .iHold           (state == ST_DONE),
        .iTimeout_value  (iTimeout_value),
        .oTimeout_enable (cmdBus.oTimeout_enable),
        .oTimeout        (timeoutHit)
    );

    assign cmdBus.oTimeout      = timeoutHit;
    assign cmdBus.oNew_command  = (state == ST_ISSUE);
    assign cmdBus.oCmd_index    = cmdIndex;
    assign cmdBus.oCmd_argument = cmdArgument;

    assign oGnt0  = gnt0;
    assign oGnt1  = gnt1;
    assign oDone0 = (state == ST_DONE) && gnt0;
    assign oDone1 = (state == ST_DONE) && gnt1;
    assign oErr   = errCode;
    assign oRsp   = rspReg;

endmodule
